// File: rtl/grad_norm_acc_pkg.sv
// Shared definitions for the gradient-magnitude accumulator: FSM states,
// default frame size and the counter-width helper.
package grad_norm_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_N_PIX = 4096;

  // Width of a counter that must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/grad_norm_acc_abs_pipe.sv
// Registered absolute value of one signed sample.
// The result is one bit wider than the input, so the most negative value stays exact.
module abs_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic signed [WIDTH-1:0] data,
  output logic        [WIDTH:0]   mag,
  output logic                    mag_valid
);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] abs_val;

  always_comb begin
    ext     = {data[WIDTH-1], data};
    abs_val = data[WIDTH-1] ? -ext : ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag       <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag       <= abs_val;
      mag_valid <= valid;
    end
  end

endmodule

// File: rtl/grad_norm_acc.sv
// Per-pixel |Dx|+|Dy| and frame-total (TV norm) accumulation over one
// N_PIX frame. The frame is armed by a start pulse and finishes with a done pulse.
//
// state | meaning
// IDLE  | waiting for i_start; o_sum holds the last frame total
// RUN   | accepting samples until the last pixel of the frame
// DRAIN | two cycles while the abs/sum pipeline empties
module grad_norm_acc
  import grad_norm_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_PIX = DEFAULT_N_PIX,
  parameter int ACC_W = 45
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_datax,
  input  logic signed [WIDTH-1:0] i_datay,
  output logic                    o_valid,
  output logic        [WIDTH:0]   o_mag,
  output logic        [ACC_W-1:0] o_sum,
  output logic                    o_done,
  output logic                    o_busy
);

  localparam int CNT_W = cnt_width(N_PIX);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] pix_cnt;
  logic             drain_cnt;
  logic             accept;
  logic             last;
  logic             clear;
  logic             done_nx;
  logic [WIDTH:0]   mag_x;
  logic [WIDTH:0]   mag_y;
  logic             vld_x;
  logic             vld_y;
  logic             s1_valid;
  logic [WIDTH:0]   mag_sum;
  logic [ACC_W-1:0] acc;

  assign accept   = (state == RUN) && i_valid;
  assign last     = accept && (pix_cnt == CNT_W'(N_PIX - 1));
  assign s1_valid = vld_x & vld_y;
  assign mag_sum  = mag_x + mag_y;

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          clear    = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      o_done    <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      o_done    <= done_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pix_cnt <= '0;
    end else if (clear) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

  abs_pipe #(.WIDTH(WIDTH)) u_abs_x (
    .clk       (i_clk),
    .rst       (i_reset),
    .valid     (accept),
    .data      (i_datax),
    .mag       (mag_x),
    .mag_valid (vld_x)
  );

  abs_pipe #(.WIDTH(WIDTH)) u_abs_y (
    .clk       (i_clk),
    .rst       (i_reset),
    .valid     (accept),
    .data      (i_datay),
    .mag       (mag_y),
    .mag_valid (vld_y)
  );

  // Accumulator is updated on the same edge that presents o_mag, so o_sum
  // and o_mag always reflect the same set of samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_mag   <= '0;
      acc     <= '0;
    end else begin
      o_valid <= s1_valid;
      o_mag   <= mag_sum;
      if (clear) begin
        acc <= '0;
      end else if (s1_valid) begin
        acc <= acc + ACC_W'(mag_sum);
      end
    end
  end

  assign o_sum  = acc;
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_grad_norm_acc.sv
// Scoreboard bench for grad_norm_acc: the driver pushes expected magnitudes and
// frame totals, and a negedge monitor pops and compares them against the DUT outputs.
module tb_grad_norm_acc;

  localparam int WIDTH = 32;
  localparam int N_PIX = 4096;
  localparam int ACC_W = 45;

  localparam int M_BASIC   = 0;
  localparam int M_RANDOM  = 1;
  localparam int M_EXTREME = 2;
  localparam int M_BUBBLE  = 3;
  localparam int M_IGNORE  = 4;

  logic                    i_clk = 1'b0;
  logic                    i_reset;
  logic                    i_start;
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_datax;
  logic signed [WIDTH-1:0] i_datay;
  logic                    o_valid;
  logic        [WIDTH:0]   o_mag;
  logic        [ACC_W-1:0] o_sum;
  logic                    o_done;
  logic                    o_busy;

  grad_norm_acc #(.WIDTH(WIDTH), .N_PIX(N_PIX), .ACC_W(ACC_W)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_datax (i_datax),
    .i_datay (i_datay),
    .o_valid (o_valid),
    .o_mag   (o_mag),
    .o_sum   (o_sum),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          vcount  = 0;
  int          done_count = 0;
  int          frames_done = 0;
  logic [63:0] exp_mag_q[$];
  logic [63:0] exp_sum_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] absv(input int signed v);
    longint l;
    l = longint'(v);
    return (l < 0) ? 64'(-l) : 64'(l);
  endfunction

  function automatic int signed rnd_sample();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'sh8000_0000;
    if (r == 1) return 32'sh7fff_ffff;
    return $urandom;
  endfunction

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_valid) begin
        vcount++;
        if (exp_mag_q.size() == 0) begin
          check("unexpected_o_valid", 64'(o_valid), 64'd0);
        end else begin
          check("o_mag", 64'(o_mag), exp_mag_q.pop_front());
        end
      end
      if (o_done) begin
        done_count++;
        if (exp_sum_q.size() == 0) begin
          check("unexpected_o_done", 64'(o_done), 64'd0);
        end else begin
          check("o_sum_at_done", 64'(o_sum), exp_sum_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    i_valid = 1'b0;
    step();
    i_start = 1'b0;
    check("busy_after_start", 64'(o_busy), 64'd1);
    check("sum_cleared", 64'(o_sum), 64'd0);
  endtask

  // Drives one full frame; returns at the cycle where o_done is high so that the
  // next start can follow immediately.
  task automatic drive_frame(input int mode);
    int signed   bx[4];
    int signed   by[4];
    logic [63:0] sum;
    logic [63:0] m;
    int          n;
    int          v_base;
    logic        v;
    int signed   x;
    int signed   y;
    bx = '{3, -1, 0, 7};
    by = '{-4, 0, 0, 2};
    start_frame();
    v_base = vcount;
    sum = 64'd0;
    n = 0;
    while (n < N_PIX) begin
      v = (mode == M_BUBBLE) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mode == M_BASIC && n < 4) begin
        x = bx[n];
        y = by[n];
      end else if (mode == M_EXTREME) begin
        x = 32'sh8000_0000;
        y = 32'sh8000_0000;
      end else begin
        x = rnd_sample();
        y = rnd_sample();
      end
      i_start = (mode == M_IGNORE && n == 50);
      i_valid = v;
      i_datax = x;
      i_datay = y;
      if (v) begin
        m = absv(x) + absv(y);
        exp_mag_q.push_back(m);
        sum += m;
        n++;
        if (n == N_PIX) exp_sum_q.push_back(sum);
      end
      step();
    end
    i_start = 1'b0;
    i_valid = (mode == M_IGNORE);
    i_datax = rnd_sample();
    i_datay = rnd_sample();
    check("busy_in_drain", 64'(o_busy), 64'd1);
    step();
    check("done_not_early", 64'(o_done), 64'd0);
    check("sum_final_before_done", 64'(o_sum), sum);
    step();
    i_valid = 1'b0;
    check("done_timing", 64'(o_done), 64'd1);
    check("busy_low_at_done", 64'(o_busy), 64'd0);
    check("frame_sum", 64'(o_sum), sum);
    check("frame_valid_count", 64'(vcount - v_base), 64'(N_PIX));
    frames_done++;
  endtask

  initial begin
    logic [63:0] held_sum;
    int          v_base;
    int          d_base;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_datax = '0;
    i_datay = '0;
    repeat (3) step();
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_mag", 64'(o_mag), 64'd0);
    check("reset_o_sum", 64'(o_sum), 64'd0);
    check("reset_o_done", 64'(o_done), 64'd0);
    check("reset_o_busy", 64'(o_busy), 64'd0);
    i_reset = 1'b0;
    step();

    // i_valid in IDLE before any frame must be dropped.
    i_valid = 1'b1;
    i_datax = 32'sd100;
    i_datay = 32'sd100;
    repeat (3) step();
    i_valid = 1'b0;
    step();
    check("idle_valid_dropped", 64'(vcount), 64'd0);

    drive_frame(M_BASIC);
    drive_frame(M_RANDOM);
    drive_frame(M_EXTREME);
    check("extreme_sum", 64'(o_sum), 64'd1 << 44);
    step();
    drive_frame(M_BUBBLE);
    step();
    drive_frame(M_IGNORE);
    held_sum = 64'(o_sum);
    step();
    v_base = vcount;
    d_base = done_count;
    repeat (6) begin
      i_valid = ($urandom_range(0, 1) == 1);
      i_datax = rnd_sample();
      i_datay = rnd_sample();
      step();
    end
    i_valid = 1'b0;
    repeat (3) step();
    check("idle_sum_held", 64'(o_sum), held_sum);
    check("idle_no_valid", 64'(vcount - v_base), 64'd0);
    check("idle_no_done", 64'(done_count - d_base), 64'd0);

    start_frame();
    for (int k = 0; k < 100; k++) begin
      i_valid = 1'b1;
      i_datax = rnd_sample();
      i_datay = rnd_sample();
      exp_mag_q.push_back(absv(i_datax) + absv(i_datay));
      step();
    end
    i_valid = 1'b0;
    d_base = done_count;
    i_reset = 1'b1;
    #1;
    check("midreset_o_valid", 64'(o_valid), 64'd0);
    check("midreset_o_mag", 64'(o_mag), 64'd0);
    check("midreset_o_sum", 64'(o_sum), 64'd0);
    check("midreset_o_done", 64'(o_done), 64'd0);
    check("midreset_o_busy", 64'(o_busy), 64'd0);
    exp_mag_q.delete();
    step();
    step();
    i_reset = 1'b0;
    repeat (4) step();
    check("midreset_no_done", 64'(done_count - d_base), 64'd0);
    drive_frame(M_RANDOM);

    repeat (5) step();
    check("total_done_count", 64'(done_count), 64'(frames_done));
    check("mag_queue_empty", 64'(exp_mag_q.size()), 64'd0);
    check("sum_queue_empty", 64'(exp_sum_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
